// File: rtl/led_cntr_pkg.sv
// Shared types and constants for the LED counter register-port arbiter.
package led_cntr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // LED counter S00_AXI register byte offsets
  localparam logic [3:0] LED_REG0 = 4'h0;
  localparam logic [3:0] LED_REG1 = 4'h4;
  localparam logic [3:0] LED_REG2 = 4'h8;
  localparam logic [3:0] LED_REG3 = 4'hC;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above i_ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  logic [PW:0] w_cand;
  logic        w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      // i_ptr < NREQ, so one subtraction is enough to wrap
      w_cand = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_cand >= (PW+1)'(NREQ)) w_cand = w_cand - (PW+1)'(NREQ);
      if (!w_found && i_req[w_cand[PW-1:0]]) begin
        w_found                  = 1'b1;
        o_grant[w_cand[PW-1:0]]  = 1'b1;
        o_idx                    = w_cand[PW-1:0];
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/led_cntr_cfg_arbiter.sv
// Round-robin sharing of the LED counter AXI4-Lite register port, one transaction in flight.
// Optional slave-response watchdog enabled by defining LED_ARB_TIMEOUT_EN.
module led_cntr_cfg_arbiter
  import led_cntr_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*32-1:0]     req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic [1:0]             rsp_resp,
  output logic [ADDR_W-1:0]      M_AXI_AWADDR,
  output logic [2:0]             M_AXI_AWPROT,
  output logic                   M_AXI_AWVALID,
  input  logic                   M_AXI_AWREADY,
  output logic [31:0]            M_AXI_WDATA,
  output logic [3:0]             M_AXI_WSTRB,
  output logic                   M_AXI_WVALID,
  input  logic                   M_AXI_WREADY,
  input  logic [1:0]             M_AXI_BRESP,
  input  logic                   M_AXI_BVALID,
  output logic                   M_AXI_BREADY,
  output logic [ADDR_W-1:0]      M_AXI_ARADDR,
  output logic [2:0]             M_AXI_ARPROT,
  output logic                   M_AXI_ARVALID,
  input  logic                   M_AXI_ARREADY,
  input  logic [31:0]            M_AXI_RDATA,
  input  logic [1:0]             M_AXI_RRESP,
  input  logic                   M_AXI_RVALID,
  output logic                   M_AXI_RREADY
);

  localparam int PW = $clog2(NREQ);

  state_t             r_state, w_nxt;
  logic [PW-1:0]      r_ptr, r_gnt, w_idx;
  logic [NREQ-1:0]    r_req_ready, w_grant;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata, r_rdata;
  logic [1:0]         r_resp;
  logic               r_aw_done, r_w_done;
  logic               w_any, w_aw_ok, w_w_ok, w_tmo, w_tmo_fire;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // AW and W complete independently; each is done once its handshake has been seen
  assign w_aw_ok = r_aw_done | M_AXI_AWREADY;
  assign w_w_ok  = r_w_done  | M_AXI_WREADY;

`ifdef LED_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_tmo_cnt;
  logic          w_busy;

  assign w_busy = (r_state == ST_WADDR) || (r_state == ST_WRESP) ||
                  (r_state == ST_RADDR) || (r_state == ST_RDATA);
  assign w_tmo  = w_busy && (r_tmo_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                          r_tmo_cnt <= '0;
    else if (!w_busy || w_nxt != r_state)  r_tmo_cnt <= '0;
    else                                   r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_nxt = req_we[w_idx] ? ST_WADDR : ST_RADDR;
      ST_WADDR: if (w_aw_ok && w_w_ok) w_nxt = ST_WRESP;
      ST_WRESP: if (M_AXI_BVALID) w_nxt = ST_DONE;
      ST_RADDR: if (M_AXI_ARREADY) w_nxt = ST_RDATA;
      ST_RDATA: if (M_AXI_RVALID) w_nxt = ST_DONE;
      ST_DONE:  w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
    // watchdog only wins when the slave made no progress this cycle
    w_tmo_fire = w_tmo && (w_nxt == r_state);
    if (w_tmo_fire) w_nxt = ST_DONE;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_req_ready <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_resp      <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_req_ready <= '0;
      case (r_state)
        ST_IDLE: if (w_any) begin
          r_gnt       <= w_idx;
          r_req_ready <= w_grant;
          r_addr      <= req_addr[w_idx*ADDR_W +: ADDR_W];
          r_wdata     <= req_wdata[w_idx*32 +: 32];
          r_aw_done   <= 1'b0;
          r_w_done    <= 1'b0;
        end
        ST_WADDR: begin
          if (M_AXI_AWREADY) r_aw_done <= 1'b1;
          if (M_AXI_WREADY)  r_w_done  <= 1'b1;
        end
        ST_WRESP: if (M_AXI_BVALID) begin
          r_resp  <= M_AXI_BRESP;
          r_rdata <= '0;
        end
        ST_RDATA: if (M_AXI_RVALID) begin
          r_resp  <= M_AXI_RRESP;
          r_rdata <= M_AXI_RDATA;
        end
        ST_DONE: r_ptr <= (r_gnt == PW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
        default: ;
      endcase
      if (w_tmo_fire) begin
        r_resp  <= AXI_RESP_SLVERR;
        r_rdata <= '0;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (r_state == ST_DONE) rsp_valid[r_gnt] = 1'b1;
  end

  assign req_ready     = r_req_ready;
  assign rsp_rdata     = (r_state == ST_DONE) ? r_rdata : '0;
  assign rsp_resp      = (r_state == ST_DONE) ? r_resp  : '0;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_AWVALID = (r_state == ST_WADDR) && !r_aw_done;
  assign M_AXI_WVALID  = (r_state == ST_WADDR) && !r_w_done;
  assign M_AXI_WSTRB   = {4{M_AXI_WVALID}};
  assign M_AXI_BREADY  = (r_state == ST_WRESP);
  assign M_AXI_ARVALID = (r_state == ST_RADDR);
  assign M_AXI_RREADY  = (r_state == ST_RDATA);

endmodule

// File: tb/tb_led_cntr_cfg_arbiter.sv
// Randomized bench: behavioural AXI4-Lite slave plus a queue-based arbitration/register model.
// Watchdog scenario runs only when LED_ARB_TIMEOUT_EN is defined.
module tb_led_cntr_cfg_arbiter;
  import led_cntr_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 4;
  localparam int TMO  = 32;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [NREQ-1:0]    req_valid = '0, req_we = '0, req_ready, rsp_valid;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*32-1:0] req_wdata = '0;
  logic [31:0]        rsp_rdata, M_AXI_WDATA, s_rdata;
  logic [1:0]         rsp_resp, s_bresp, s_rresp;
  logic [AW-1:0]      M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]         M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]         M_AXI_WSTRB;
  logic M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;

  led_cntr_cfg_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(s_awready),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(s_wready),
    .M_AXI_BRESP(s_bresp), .M_AXI_BVALID(s_bvalid), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(s_arready),
    .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp), .M_AXI_RVALID(s_rvalid),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  // ---------------- slave model ----------------
  // rdy_mode 0: random readies; 1: WREADY at once, AWREADY 3 cycles later; 2: both together after 2 cycles
  int          rdy_mode = 0;
  logic        stall_b = 1'b0, stall_r = 1'b0;
  logic        r_awr, r_wr, r_arr, aw_have, w_have, ar_have;
  logic [AW-1:0] aw_a, ar_a;
  logic [31:0] w_d;
  logic [3:0]  last_wstrb;
  logic [2:0]  last_prot;
  int          aw_wait, aw_cnt = 0, w_cnt = 0;
  logic [31:0] s_mem [4];

  assign s_awready = (rdy_mode == 0) ? r_awr : (rdy_mode == 1) ? (aw_wait >= 3) : (aw_wait >= 2);
  assign s_wready  = (rdy_mode == 0) ? r_wr  : (rdy_mode == 1) ? 1'b1 : (aw_wait >= 2);
  assign s_arready = r_arr;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_awr <= 1'b0; r_wr <= 1'b0; r_arr <= 1'b0; aw_wait <= 0;
      aw_have <= 1'b0; w_have <= 1'b0; ar_have <= 1'b0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_bresp <= 2'b00; s_rresp <= 2'b00; s_rdata <= '0;
    end else begin
      r_awr   <= 1'($urandom_range(0, 1));
      r_wr    <= 1'($urandom_range(0, 1));
      r_arr   <= 1'($urandom_range(0, 1));
      aw_wait <= M_AXI_AWVALID ? aw_wait + 1 : 0;
      if (M_AXI_AWVALID && s_awready) begin
        aw_cnt <= aw_cnt + 1; aw_have <= 1'b1; aw_a <= M_AXI_AWADDR; last_prot <= M_AXI_AWPROT;
      end
      if (M_AXI_WVALID && s_wready) begin
        w_cnt <= w_cnt + 1; w_have <= 1'b1; w_d <= M_AXI_WDATA; last_wstrb <= M_AXI_WSTRB;
      end
      if (s_bvalid) begin
        if (M_AXI_BREADY) s_bvalid <= 1'b0;
      end else if (aw_have && w_have && !stall_b && $urandom_range(0, 1) == 1) begin
        s_bvalid <= 1'b1; s_bresp <= AXI_RESP_OKAY; s_mem[aw_a[3:2]] <= w_d;
        aw_have <= 1'b0; w_have <= 1'b0;
      end
      if (M_AXI_ARVALID && s_arready) begin ar_have <= 1'b1; ar_a <= M_AXI_ARADDR; end
      if (s_rvalid) begin
        if (M_AXI_RREADY) s_rvalid <= 1'b0;
      end else if (ar_have && !stall_r && $urandom_range(0, 1) == 1) begin
        s_rvalid <= 1'b1; s_rresp <= AXI_RESP_OKAY; s_rdata <= s_mem[ar_a[3:2]]; ar_have <= 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {req_ready, rsp_valid, rsp_rdata, rsp_resp, M_AXI_AWVALID, M_AXI_WVALID,
              M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, M_AXI_WSTRB,
              M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA}, '0);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [7:0] idx; logic [31:0] rdata; logic [1:0] resp; } rsp_t;
  rsp_t        rsp_q[$];
  int          grant_q[$];
  int          m_ptr = 0, m_nwr = 0;
  logic [31:0] m_mem [4] = '{default: 32'h0};

  // one clock as a requester sees it: drop valid on accept, collect completions
  task automatic cyc();
    @(negedge ACLK);
    for (int i = 0; i < NREQ; i++) begin
      if (rsp_valid[i]) rsp_q.push_back('{idx: 8'(i), rdata: rsp_rdata, resp: rsp_resp});
      if (req_ready[i]) begin grant_q.push_back(i); req_valid[i] = 1'b0; end
    end
  endtask

  task automatic run_batch(input string tag, input logic [NREQ-1:0] mask, input logic [NREQ-1:0] we,
                           input logic [NREQ*AW-1:0] addr, input logic [NREQ*32-1:0] wd);
    int order[$];
    logic [NREQ-1:0] pend;
    int p, budget;
    pend = mask;
    p    = m_ptr;
    while (pend != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (p + k) % NREQ;
        if (pend[j]) begin order.push_back(j); pend[j] = 1'b0; p = (j + 1) % NREQ; break; end
      end
    end
    rsp_q.delete(); grant_q.delete();
    req_we = we; req_addr = addr; req_wdata = wd; req_valid = mask;
    budget = 0;
    while (rsp_q.size() < order.size() && budget < 100 * NREQ) begin cyc(); budget++; end
    req_valid = '0;
    chk({tag, "/rsp_count"}, rsp_q.size(), order.size());
    foreach (order[n]) begin
      int g;
      logic [AW-1:0] a;
      logic [31:0] exp_d;
      g = order[n];
      a = addr[g*AW +: AW];
      if (we[g]) begin m_mem[a[3:2]] = wd[g*32 +: 32]; exp_d = '0; m_nwr++; end
      else exp_d = m_mem[a[3:2]];
      m_ptr = (g + 1) % NREQ;
      if (n < grant_q.size()) chk({tag, "/grant"}, grant_q[n], g);
      if (n < rsp_q.size()) begin
        chk({tag, "/idx"}, rsp_q[n].idx, g);
        chk({tag, "/rdata"}, rsp_q[n].rdata, exp_d);
        chk({tag, "/resp"}, rsp_q[n].resp, AXI_RESP_OKAY);
      end
    end
    chk({tag, "/aw_beats"}, aw_cnt, m_nwr);
    chk({tag, "/w_beats"}, w_cnt, m_nwr);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [3:0] offs [4];
    int n;
    offs = '{LED_REG0, LED_REG1, LED_REG2, LED_REG3};

    repeat (3) @(negedge ACLK);
    chk_quiet("reset_outputs");
    ARESETN = 1'b1;
    cyc();

    run_batch("wr0", 2'b01, 2'b01, {4'h0, LED_REG0}, {32'h0, 32'h0000_0001});
    chk("wr0/awaddr", aw_a, LED_REG0);
    chk("wr0/wdata", w_d, 32'h1);
    chk("wr0/wstrb", last_wstrb, 4'hF);
    chk("wr0/awprot", last_prot, 3'b000);

    for (int i = 0; i < 4; i++)
      run_batch("wr_regs", 2'b01, 2'b01, {4'h0, offs[i]}, {32'h0, 32'(i + 1)});
    for (int i = 0; i < 4; i++)
      run_batch("rd_regs", 2'b10, 2'b00, {offs[i], 4'h0}, '0);

    run_batch("both_a", 2'b11, 2'b00, {LED_REG1, LED_REG0}, '0);
    chk("both_a/first", grant_q.size() > 0 ? grant_q[0] : -1, 0);
    run_batch("solo0", 2'b01, 2'b01, {4'h0, LED_REG2}, {32'h0, 32'hCAFE_0003});
    run_batch("both_b", 2'b11, 2'b00, {LED_REG2, LED_REG3}, '0);
    chk("both_b/first", grant_q.size() > 0 ? grant_q[0] : -1, 1);

    rdy_mode = 1;
    run_batch("w_before_aw", 2'b10, 2'b10, {LED_REG1, 4'h0}, {32'hA5A5_0001, 32'h0});
    rdy_mode = 2;
    run_batch("aw_w_same", 2'b01, 2'b01, {4'h0, LED_REG3}, {32'h0, 32'h5A5A_0002});
    rdy_mode = 0;
    run_batch("rd_back", 2'b11, 2'b00, {LED_REG1, LED_REG3}, '0);

    for (int t = 0; t < 25; t++) begin
      logic [NREQ-1:0] mk, wm;
      logic [NREQ*AW-1:0] ad;
      logic [NREQ*32-1:0] wd;
      mk = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      wm = NREQ'($urandom());
      for (int i = 0; i < NREQ; i++) begin
        ad[i*AW +: AW] = offs[$urandom_range(0, 3)];
        wd[i*32 +: 32] = $urandom();
      end
      rdy_mode = $urandom_range(0, 2);
      run_batch("rand", mk, wm, ad, wd);
    end
    rdy_mode = 0;

    // reset while the read is waiting on RDATA
    stall_r = 1'b1;
    req_we = '0; req_addr = {4'h0, LED_REG1}; req_valid = 2'b01;
    n = 0;
    while (!M_AXI_RREADY && n < 50) begin cyc(); n++; end
    chk("rst_mid/reached_rdata", M_AXI_RREADY, 1'b1);
    #2 ARESETN = 1'b0;
    #1 chk_quiet("rst_mid/outputs");
    req_valid = '0;
    rsp_q.delete();
    cyc(); cyc();
    ARESETN = 1'b1;
    m_ptr = 0;
    stall_r = 1'b0;
    repeat (5) cyc();
    chk("rst_mid/no_lost_rsp", rsp_q.size(), 0);
    run_batch("rst_mid/new_read", 2'b01, 2'b00, {4'h0, LED_REG1}, '0);

`ifdef LED_ARB_TIMEOUT_EN
    begin
      int cycles;
      stall_b = 1'b1;
      rsp_q.delete();
      req_we = 2'b01; req_addr = {4'h0, LED_REG0}; req_wdata = {32'h0, 32'hDEAD_BEEF}; req_valid = 2'b01;
      cycles = 0;
      while (rsp_q.size() == 0 && cycles < TMO + 60) begin cyc(); cycles++; end
      chk("tmo/rsp_seen", rsp_q.size(), 1);
      if (rsp_q.size() > 0) begin
        chk("tmo/resp", rsp_q[0].resp, AXI_RESP_SLVERR);
        chk("tmo/rdata", rsp_q[0].rdata, 32'h0);
      end
      chk("tmo/not_early", cycles >= TMO, 1'b1);
      cyc();
      chk("tmo/idle_after", {M_AXI_BREADY, M_AXI_AWVALID, M_AXI_WVALID, rsp_valid}, '0);
      req_valid = '0;
      ARESETN = 1'b0;
      cyc();
      ARESETN = 1'b1;
      stall_b = 1'b0;
      m_ptr = 0;
      m_nwr = aw_cnt;
      cyc();
      run_batch("tmo/recover", 2'b01, 2'b00, {4'h0, LED_REG0}, '0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
